// File: rtl/byte_word_loader.sv
// Sequences byte reads from an 8-bit memory and loads them into a downstream
// 32-bit register as a zero/sign-extended byte, halfword, or four shifted bytes.
module byte_word_loader (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Mode,
  input  logic [31:0] Addr,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [7:0]  MemData,
  output logic        RegE,
  output logic [2:0]  RegFunSel,
  output logic [31:0] RegI,
  output logic        Busy,
  output logic        Done
);

  // state | meaning
  // IDLE  | waiting for Start
  // REQ   | requesting byte at ptr_q (first cycle after a non-writing ack is a gap)
  // WRITE | one-cycle load into the downstream register
  // DONE  | one-cycle completion pulse
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [7:0]  bn_q, bn_d;
  logic        gap_q, gap_d;

  logic [2:0]  last_idx;
  logic        byte_wr;

  always_comb begin
    case (mode_q)
      2'b00:   last_idx = 3'd0;
      2'b10:   last_idx = 3'd3;
      default: last_idx = 3'd1;
    endcase
  end

  // Word mode shifts every byte in; the other modes write only once, after the last byte.
  assign byte_wr = (mode_q == 2'b10) || (cnt_q == last_idx);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    bn_d    = bn_q;
    gap_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          ptr_d   = Addr;
          mode_d  = Mode;
          cnt_d   = 3'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!gap_q && MemAck) begin
          ptr_d = ptr_q + 32'd1;
          cnt_d = cnt_q + 3'd1;
          bn_d  = MemData;
          if (cnt_q == 3'd0) b0_d = MemData;
          if (cnt_q == 3'd1) b1_d = MemData;
          if (byte_wr) state_d = WRITE;
          else         gap_d   = 1'b1;
        end
      end
      WRITE: begin
        if (cnt_q == last_idx + 3'd1) state_d = DONE;
        else                          state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      bn_q    <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      bn_q    <= bn_d;
      gap_q   <= gap_d;
    end
  end

  assign MemReq    = (state_q == REQ) && !gap_q;
  assign MemAddr   = MemReq ? ptr_q : 32'd0;
  assign RegE      = (state_q == WRITE);
  assign RegFunSel = RegE ? {1'b1, mode_q} : 3'b000;
  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);

  always_comb begin
    RegI = 32'd0;
    if (RegE) begin
      case (mode_q)
        2'b00:   RegI = {24'd0, b0_q};
        2'b10:   RegI = {24'd0, bn_q};
        default: RegI = {16'd0, b0_q, b1_q};
      endcase
    end
  end

endmodule

// File: tb/tb_byte_word_loader.sv
// Directed bench for byte_word_loader: each load mode, wait states, address wrap,
// mid-transfer reset, and ignored Start/MemAck.
module tb_byte_word_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Mode = 2'b00;
  logic [31:0] Addr = 32'd0;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [7:0]  MemData = 8'd0;
  logic        RegE;
  logic [2:0]  RegFunSel;
  logic [31:0] RegI;
  logic        Busy;
  logic        Done;

  int total = 0;
  int bad   = 0;

  byte_word_loader dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode), .Addr(Addr),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
    .RegE(RegE), .RegFunSel(RegFunSel), .RegI(RegI), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_memreq"}, {31'd0, MemReq}, 32'd0);
    chk({tag, "_memaddr"}, MemAddr, 32'd0);
    chk({tag, "_rege"}, {31'd0, RegE}, 32'd0);
    chk({tag, "_funsel"}, {29'd0, RegFunSel}, 32'd0);
    chk({tag, "_regi"}, RegI, 32'd0);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, Done}, 32'd0);
  endtask

  // One complete load; expected register traffic is derived from the mode and the bytes.
  task automatic run_load(input string tag, input logic [1:0] mode, input logic [31:0] addr,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3,
                          input int waitc, input bit poke);
    logic [7:0]  dat [4];
    logic [31:0] a;
    logic [31:0] exp_i;
    logic [2:0]  exp_fs;
    int          nb;
    bit          wr;
    dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3;
    nb = (mode == 2'b00) ? 1 : (mode == 2'b10) ? 4 : 2;
    case (mode)
      2'b00:   exp_fs = 3'b100;
      2'b01:   exp_fs = 3'b101;
      2'b10:   exp_fs = 3'b110;
      default: exp_fs = 3'b111;
    endcase
    Start = 1'b1; Mode = mode; Addr = addr;
    tick();
    Start = 1'b0; Mode = ~mode; Addr = 32'hDEAD_BEEF;
    chk({tag, "_busy_start"}, {31'd0, Busy}, 32'd1);
    for (int n = 0; n < nb; n++) begin
      a = addr + n;
      for (int w = 0; w < waitc; w++) begin
        chk({tag, "_wait_memreq"}, {31'd0, MemReq}, 32'd1);
        chk({tag, "_wait_memaddr"}, MemAddr, a);
        chk({tag, "_wait_rege"}, {31'd0, RegE}, 32'd0);
        Start = poke;
        tick();
        Start = 1'b0;
      end
      chk({tag, "_req_memreq"}, {31'd0, MemReq}, 32'd1);
      chk({tag, "_req_memaddr"}, MemAddr, a);
      chk({tag, "_req_rege"}, {31'd0, RegE}, 32'd0);
      MemAck = 1'b1; MemData = dat[n];
      tick();
      MemAck = 1'b0; MemData = 8'hEE;
      wr = (mode == 2'b10) || (n == nb - 1);
      chk({tag, "_post_ack_memreq"}, {31'd0, MemReq}, 32'd0);
      if (wr) begin
        if (mode == 2'b00 || mode == 2'b10) exp_i = {24'd0, dat[n]};
        else                                exp_i = {16'd0, dat[0], dat[1]};
        chk({tag, "_wr_rege"}, {31'd0, RegE}, 32'd1);
        chk({tag, "_wr_funsel"}, {29'd0, RegFunSel}, {29'd0, exp_fs});
        chk({tag, "_wr_regi"}, RegI, exp_i);
      end else begin
        chk({tag, "_gap_rege"}, {31'd0, RegE}, 32'd0);
        chk({tag, "_gap_regi"}, RegI, 32'd0);
      end
      Start = poke;
      tick();
      Start = 1'b0;
    end
    chk({tag, "_done"}, {31'd0, Done}, 32'd1);
    chk({tag, "_done_busy"}, {31'd0, Busy}, 32'd1);
    chk({tag, "_done_rege"}, {31'd0, RegE}, 32'd0);
    tick();
    chk_quiet({tag, "_idle"});
    tick();
    chk_quiet({tag, "_idle2"});
  endtask

  initial begin
    #2;
    chk_quiet("reset");
    tick();
    Reset = 1'b1;
    tick();
    chk_quiet("after_release");

    // Byte, zero-wait: REQ at T+1, WRITE at T+2, Done at T+3, IDLE at T+4.
    run_load("m00", 2'b00, 32'h0000_0100, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 1'b0);
    // Signed halfword.
    run_load("m11", 2'b11, 32'h0000_0200, 8'h80, 8'h01, 8'h00, 8'h00, 0, 1'b0);
    // Word, three wait cycles per byte, with Start poked while busy.
    run_load("m10", 2'b10, 32'h0000_0300, 8'h12, 8'h34, 8'h56, 8'h78, 3, 1'b1);
    // Unsigned halfword across the address wrap.
    run_load("m01", 2'b01, 32'hFFFF_FFFF, 8'hC3, 8'h5A, 8'h00, 8'h00, 1, 1'b0);

    // MemAck in IDLE must do nothing.
    MemAck = 1'b1; MemData = 8'h99;
    tick();
    chk_quiet("ack_idle1");
    tick();
    chk_quiet("ack_idle2");
    MemAck = 1'b0;

    // Abort a word load while requesting its third byte.
    Start = 1'b1; Mode = 2'b10; Addr = 32'h0000_0400;
    tick();
    Start = 1'b0;
    MemAck = 1'b1; MemData = 8'h11;
    tick();
    MemAck = 1'b0;
    chk("abort_wr0", {31'd0, RegE}, 32'd1);
    tick();
    MemAck = 1'b1; MemData = 8'h22;
    tick();
    MemAck = 1'b0;
    chk("abort_wr1", RegI, 32'h0000_0022);
    tick();
    chk("abort_req2_memreq", {31'd0, MemReq}, 32'd1);
    chk("abort_req2_memaddr", MemAddr, 32'h0000_0402);
    #2;
    Reset = 1'b0;
    #1;
    chk_quiet("abort_async");
    tick();
    chk_quiet("abort_held");
    Reset = 1'b1;
    MemAck = 1'b1; MemData = 8'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("abort_after");
    end
    MemAck = 1'b0;

    // First Start after reset is accepted straight away.
    run_load("post_rst", 2'b00, 32'h0000_0500, 8'h7E, 8'h00, 8'h00, 8'h00, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
